// File: rtl/time_entry_loader.sv
// Keypad-side MM:SS entry buffer and one-shot parallel loader for the timer counter chain.
// Optional ENTRY_CLAMP_EN: START with seconds tens > 5 clamps to x5:9 and loads instead of rejecting.
module time_entry_loader #(
  parameter logic [3:0] KEY_CANCEL = 4'hA,
  parameter logic [3:0] KEY_START  = 4'hB
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic [2:0] entry_count,
  output logic       reject
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  state_t          state, state_n;
  logic [3:0][3:0] dig, dig_n;       // [3]=min_tens .. [0]=sec_ones
  logic [2:0]      count, count_n;
  logic            loadn_n, reject_n;
  logic            seen_busy, seen_n;

  logic is_digit, is_cancel, is_start;
  assign is_digit  = key_code <= 4'd9;
  assign is_cancel = key_code == KEY_CANCEL;
  assign is_start  = key_code == KEY_START;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      dig       <= '0;
      count     <= '0;
      loadn     <= 1'b1;
      reject    <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      state     <= state_n;
      dig       <= dig_n;
      count     <= count_n;
      loadn     <= loadn_n;
      reject    <= reject_n;
      seen_busy <= seen_n;
    end
  end

  always_comb begin
    state_n  = state;
    dig_n    = dig;
    count_n  = count;
    loadn_n  = 1'b1;
    reject_n = 1'b0;
    seen_n   = seen_busy;
    if (key_valid && is_cancel) begin
      // Cancel wins over everything, including the RUN exit on the same edge.
      state_n = IDLE;
      dig_n   = '0;
      count_n = '0;
      seen_n  = 1'b0;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (key_valid) begin
            if (is_digit) begin
              if (count < 3'd4) begin
                dig_n   = {dig[2:0], key_code};
                count_n = count + 3'd1;
                state_n = ENTRY;
              end else begin
                reject_n = 1'b1;
              end
            end else if (is_start) begin
              if (state == IDLE || timer_busy) begin
                reject_n = 1'b1;
              end else if (dig[1] <= 4'd5) begin
                state_n = LOAD;
                loadn_n = 1'b0;
              end else begin
`ifdef ENTRY_CLAMP_EN
                dig_n[1] = 4'd5;
                dig_n[0] = 4'd9;
                state_n  = LOAD;
                loadn_n  = 1'b0;
`else
                reject_n = 1'b1;
`endif
              end
            end else begin
              reject_n = 1'b1;
            end
          end
        end
        LOAD: begin
          // Digits stay put through this cycle so the counters latch a stable value.
          state_n  = RUN;
          seen_n   = 1'b0;
          reject_n = key_valid;
        end
        RUN: begin
          reject_n = key_valid;
          if (timer_busy) begin
            seen_n = 1'b1;
          end else if (seen_busy) begin
            state_n = IDLE;
            dig_n   = '0;
            count_n = '0;
            seen_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign min_tens    = dig[3];
  assign min_ones    = dig[2];
  assign sec_tens    = dig[1];
  assign sec_ones    = dig[0];
  assign entry_count = count;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed plus randomized bench for time_entry_loader against a decimal-value reference model.
module tb_time_entry_loader;
  logic       clock = 1'b0, clear = 1'b0, key_valid = 1'b0, timer_busy = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, reject;
  logic [2:0] entry_count;

  time_entry_loader dut (
    .clock(clock), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .timer_busy(timer_busy), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .loadn(loadn),
    .entry_count(entry_count), .reject(reject)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  // Model keeps the entry as a plain decimal number MMSS.
  typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN} mode_t;
  mode_t mode;
  int    val, cnt;
  bit    seen;
  logic  exp_loadn, exp_rej;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    mode = M_IDLE; val = 0; cnt = 0; seen = 0; exp_loadn = 1'b1; exp_rej = 1'b0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit busy);
    exp_rej = 1'b0; exp_loadn = 1'b1;
    if (kv && kc == 10) begin
      mode = M_IDLE; val = 0; cnt = 0; seen = 0;
    end else begin
      case (mode)
        M_IDLE, M_ENTRY: if (kv) begin
          if (kc <= 9) begin
            if (cnt < 4) begin val = (val * 10 + kc) % 10000; cnt++; mode = M_ENTRY; end
            else exp_rej = 1'b1;
          end else if (kc == 11) begin
            if (mode == M_IDLE || busy) exp_rej = 1'b1;
            else if ((val / 10) % 10 <= 5) begin mode = M_LOAD; exp_loadn = 1'b0; end
            else begin
`ifdef ENTRY_CLAMP_EN
              val = (val / 100) * 100 + 59; mode = M_LOAD; exp_loadn = 1'b0;
`else
              exp_rej = 1'b1;
`endif
            end
          end else exp_rej = 1'b1;
        end
        M_LOAD: begin mode = M_RUN; seen = 0; exp_rej = kv; end
        M_RUN: begin
          exp_rej = kv;
          if (busy) seen = 1;
          else if (seen) begin mode = M_IDLE; val = 0; cnt = 0; seen = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] bus();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_digits"}, bus(), bcd(val));
    chk({tag, "_count"}, 16'(entry_count), 16'(cnt));
    chk({tag, "_loadn"}, 16'(loadn), 16'(exp_loadn));
    chk({tag, "_reject"}, 16'(reject), 16'(exp_rej));
  endtask

  task automatic cycle(input bit kv, input logic [3:0] kc, input bit busy);
    @(negedge clock);
    key_valid = kv; key_code = kc; timer_busy = busy;
    model_step(kv, int'(kc), busy);
    @(posedge clock);
    #1 check_all("cyc");
  endtask

  task automatic key(input logic [3:0] kc);
    cycle(1'b1, kc, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock) clear = 1'b1;

    // 1,3,0 START -> load of 01:30
    key(4'd1); key(4'd3); key(4'd0);
    chk("e130_digits", bus(), 16'h0130);
    chk("e130_count", 16'(entry_count), 16'd3);
    key(4'hB);
    chk("e130_loadn_low", 16'(loadn), 16'd0);
    cycle(1'b0, 4'd0, 1'b0);
    chk("e130_loadn_release", 16'(loadn), 16'd1);
    repeat (3) cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b0, 4'd0, 1'b0);
    chk("e130_exit_count", 16'(entry_count), 16'd0);

    // Saturation at four digits
    for (int k = 1; k <= 4; k++) begin
      key(4'(k));
      chk("sat_noreject", 16'(reject), 16'd0);
    end
    key(4'd5);
    chk("sat_reject", 16'(reject), 16'd1);
    chk("sat_digits", bus(), 16'h1234);
    chk("sat_count", 16'(entry_count), 16'd4);
    key(4'hA);

    // Invalid seconds 70
    key(4'd7); key(4'd0); key(4'hB);
`ifdef ENTRY_CLAMP_EN
    chk("sec70_loadn", 16'(loadn), 16'd0);
    chk("sec70_digits", bus(), 16'h0059);
`else
    chk("sec70_reject", 16'(reject), 16'd1);
    chk("sec70_loadn", 16'(loadn), 16'd1);
    chk("sec70_digits", bus(), 16'h0070);
`endif
    key(4'hA);
    cycle(1'b0, 4'd0, 1'b0);

    // Boundary sec_tens = 5, then run with a key mid-run
    key(4'd5); key(4'd9); key(4'hB);
    chk("sec59_loadn", 16'(loadn), 16'd0);
    cycle(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(i == 5, 4'd5, 1'b1);
      if (i == 5) chk("run_reject", 16'(reject), 16'd1);
    end
    cycle(1'b0, 4'd0, 1'b0);
    chk("run_exit_digits", bus(), 16'h0000);
    chk("run_exit_count", 16'(entry_count), 16'd0);

    // Cancel in entry
    key(4'd4); key(4'd2); key(4'hA);
    chk("cancel_digits", bus(), 16'h0000);
    chk("cancel_reject", 16'(reject), 16'd0);

    // START while busy, invalid code, START in IDLE
    key(4'd3);
    cycle(1'b1, 4'hB, 1'b1);
    chk("busy_start_reject", 16'(reject), 16'd1);
    chk("busy_start_loadn", 16'(loadn), 16'd1);
    key(4'hC);
    chk("code_c_reject", 16'(reject), 16'd1);
    key(4'hA);
    key(4'hB);
    chk("idle_start_reject", 16'(reject), 16'd1);

    // Cancel during RUN on the same edge busy falls
    key(4'd1); key(4'hB); cycle(1'b0, 4'd0, 1'b0); cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b1, 4'hA, 1'b0);
    chk("run_cancel_count", 16'(entry_count), 16'd0);
    chk("run_cancel_reject", 16'(reject), 16'd0);

    // Asynchronous clear in the LOAD cycle
    key(4'd2); key(4'd5); key(4'hB);
    chk("pre_clear_loadn", 16'(loadn), 16'd0);
    #2 clear = 1'b0;
    #1;
    chk("clr_loadn", 16'(loadn), 16'd1);
    chk("clr_digits", bus(), 16'h0000);
    chk("clr_count", 16'(entry_count), 16'd0);
    chk("clr_reject", 16'(reject), 16'd0);
    model_reset();
    @(negedge clock);
    clear = 1'b1; key_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/time_entry_loader.md
# time_entry_loader

Keypad-side writer for the microwave timer's cascaded digit counters. Accepts single-digit key strobes, shifts them right-to-left into a four-digit MM:SS buffer, validates the entry on START, and drives the counters' parallel-load bus with one active-low load strobe. It sits between the keypad decoder and the timer's counter chain and locks itself while the timer is running.

## Interface
Parameters:
- KEY_CANCEL, 4'hA: key code that clears the buffer and aborts entry or run.
- KEY_START, 4'hB: key code that validates the entry and loads the timer.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code valid when high.
- key_code  in  4  0–9 digits; KEY_CANCEL; KEY_START; other codes invalid.
- timer_busy  in  1  high while the timer counter chain is enabled/counting.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  parallel-load data to the four counters, registered.
- loadn  out  1  active-low load strobe to all four counters.
- entry_count  out  3  digits entered, 0–4, saturating.
- reject  out  1  one-cycle pulse on any refused key.

## Operation
- States: IDLE (count 0), ENTRY (count 1–4), LOAD, RUN.
- Digit key (0–9) in IDLE/ENTRY, count < 4: shift min_tens←min_ones←sec_tens←sec_ones←key_code; count+1; go ENTRY.
- Digit key with count = 4: buffer unchanged, reject pulse.
- Codes C–F other than the two parameters: ignored, reject pulse, in every state.
- KEY_CANCEL in any state: digits←0, count←0, go IDLE; no reject.
- KEY_START in IDLE: reject. In ENTRY with timer_busy = 1: reject, stay.
- KEY_START in ENTRY, timer_busy = 0: if sec_tens ≤ 5 go LOAD; else invalid-seconds handling (see Configuration).
- LOAD: loadn = 0 for exactly one cycle, digits held stable; next state RUN.
- RUN: digit and START keys rejected; seen_busy flag sets when timer_busy = 1; exit to IDLE with digits and count cleared on the first cycle timer_busy = 0 with seen_busy = 1.
- Digits are BCD; min_tens/min_ones accept 0–9, giving a maximum of 99:59.

## Timing
- Reset, asserted asynchronously: digits 0, entry_count 0, loadn 1, reject 0, seen_busy 0, state IDLE. A reset during LOAD releases loadn immediately.
- A key sampled at edge N updates the digits, entry_count and reject after edge N. reject is high for cycle N..N+1 only.
- START sampled at edge N: loadn is low from edge N to N+1 and high again after N+1. Digits are stable from edge N-1 through N+1.
- Back-to-back key_valid strobes on consecutive cycles are each accepted.
- CANCEL takes priority over all other conditions, including the RUN exit, on the same edge.
- loadn is never asserted while timer_busy = 1 at the START edge.

## Configuration
- ENTRY_CLAMP_EN defined: START with sec_tens > 5 clamps sec_tens to 5 and sec_ones to 9 on that edge and proceeds to LOAD. There is no reject.
- ENTRY_CLAMP_EN undefined: START with sec_tens > 5 gives a reject pulse. State stays ENTRY, the buffer is unchanged, and loadn stays 1.

## Test plan
- Reset, then keys 1,3,0 then START (timer_busy 0) → digits 0,1,3,0; entry_count 3; loadn low exactly one cycle the edge after START.
- Keys 1,2,3,4,5 → digits 1,2,3,4; entry_count 4; reject pulses only on the fifth key.
- Keys 7,0 then START (sec_tens 7): ENTRY_CLAMP_EN undefined → reject pulse, no loadn. ENTRY_CLAMP_EN defined → load of 00:59.
- After a load, raise timer_busy for 10 cycles and press 5 mid-run → reject pulse; when timer_busy falls → IDLE, digits 0, entry_count 0.
- Keys 4,2 then CANCEL, or CANCEL during RUN → digits 0, entry_count 0, IDLE, no reject.
- Assert clear during the LOAD cycle → loadn 1 immediately, all outputs at reset values.
